// File: rtl/mw8080_pkg.sv
// Shared types, constants and helpers for the Midway/Taito 8080 colour overlay.
// The struct types are sized for the default build (1-bit colour, 9-bit counters).
package mw8080_pkg;

    localparam int COLOR_W_DEF = 1;
    localparam int HC_W_DEF    = 9;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [HC_W_DEF-1:0] start;
        rgb_t                rgb;
    } band_t;

    localparam rgb_t RGB_WHITE = '1;
    localparam rgb_t RGB_BLACK = '0;

    function automatic int band_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mw8080_overlay_if.sv
// Band-table configuration port: one-cycle write strobe, band index and {start, R, G, B}.
interface mw8080_overlay_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 12
);
    logic              Cfg_We;
    logic [ADDR_W-1:0] Cfg_Addr;
    logic [DATA_W-1:0] Cfg_Data;

    modport master (output Cfg_We, Cfg_Addr, Cfg_Data);
    modport slave  (input  Cfg_We, Cfg_Addr, Cfg_Data);
endinterface

// File: rtl/mw8080_raster_cnt.sv
// Raster position tracker: falling-edge detection on the core syncs and the
// saturating horizontal/vertical counters, all advanced on pixel-enable cycles.
module mw8080_raster_cnt #(
    parameter int HC_W = 9,
    parameter int VC_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_ce,
    input  logic            hsync,
    input  logic            vsync,
    output logic [HC_W-1:0] hcount,
    output logic [VC_W-1:0] vcount,
    output logic            line_start,
    output logic            frame_start
);

    logic hsync_q;
    logic vsync_q;

    // Previous values start high so the first real sync after reset is an edge.
    assign line_start  = pix_ce & hsync_q & ~hsync;
    assign frame_start = pix_ce & vsync_q & ~vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            hcount  <= '0;
            vcount  <= '0;
        end else if (pix_ce) begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            if (line_start)
                hcount <= '0;
            else if (hcount != '1)
                hcount <= hcount + 1'b1;
            if (frame_start)
                vcount <= '0;
            else if (line_start && vcount != '1)
                vcount <= vcount + 1'b1;
        end
    end

endmodule

// File: rtl/mw8080_overlay.sv
// Run-time programmable vertical-band colour overlay for 8080 monochrome video.
// Optional backdrop colour for unlit pixels: define MW_OVERLAY_BACKDROP_EN.
module mw8080_overlay
    import mw8080_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int COLOR_W   = 1,
    parameter int HC_W      = 9,
    parameter int VC_W      = 9
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Pix_Ce,
    input  logic               Video,
    input  logic               HSync,
    input  logic               VSync,
    input  logic               Enable,
    mw8080_overlay_if.slave    cfg,
    output logic [COLOR_W-1:0] O_VIDEO_R,
    output logic [COLOR_W-1:0] O_VIDEO_G,
    output logic [COLOR_W-1:0] O_VIDEO_B,
    output logic               O_HSYNC,
    output logic               O_VSYNC,
    output logic [HC_W-1:0]    O_HCount,
    output logic [VC_W-1:0]    O_VCount
);

    localparam int BAND_AW = band_aw(NUM_BANDS);
    localparam int RGB_W   = 3 * COLOR_W;
    localparam logic [RGB_W-1:0] RGB_ONES = {RGB_W{1'b1}};

    // A band whose address is taken by the backdrop can never be programmed,
    // so it is left out of the lookup instead of shadowing the real bands.
`ifdef MW_OVERLAY_BACKDROP_EN
    localparam int NB_LOOKUP = (NUM_BANDS == (1 << BAND_AW)) ? NUM_BANDS - 1 : NUM_BANDS;
`else
    localparam int NB_LOOKUP = NUM_BANDS;
`endif

    logic [HC_W-1:0]  hcount;
    logic [VC_W-1:0]  vcount;
    logic             line_start;
    logic             frame_start;

    logic [HC_W-1:0]  sh_start  [NUM_BANDS];
    logic [RGB_W-1:0] sh_rgb    [NUM_BANDS];
    logic [HC_W-1:0]  act_start [NUM_BANDS];
    logic [RGB_W-1:0] act_rgb   [NUM_BANDS];

    logic [HC_W-1:0]  cfg_start;
    logic [RGB_W-1:0] cfg_rgb;
    logic             addr_is_bd;
    logic [RGB_W-1:0] band_rgb;
    logic [RGB_W-1:0] dark_rgb;
    logic [RGB_W-1:0] pix_rgb;

    logic [RGB_W-1:0] rgb_q;
    logic             hs_q;
    logic             vs_q;
    logic             run;

    mw8080_raster_cnt #(
        .HC_W (HC_W),
        .VC_W (VC_W)
    ) u_raster (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .pix_ce      (Pix_Ce),
        .hsync       (HSync),
        .vsync       (VSync),
        .hcount      (hcount),
        .vcount      (vcount),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    assign cfg_start = cfg.Cfg_Data[RGB_W +: HC_W];
    assign cfg_rgb   = cfg.Cfg_Data[RGB_W-1:0];

    // Commit copies the pre-write shadow; a write in the same cycle waits a line.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                sh_start[i]  <= '0;
                sh_rgb[i]    <= RGB_ONES;
                act_start[i] <= '0;
                act_rgb[i]   <= RGB_ONES;
            end
        end else begin
            if (line_start) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    act_start[i] <= sh_start[i];
                    act_rgb[i]   <= sh_rgb[i];
                end
            end
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (cfg.Cfg_We && !addr_is_bd && cfg.Cfg_Addr == BAND_AW'(i)) begin
                    sh_start[i] <= cfg_start;
                    sh_rgb[i]   <= cfg_rgb;
                end
            end
        end
    end

`ifdef MW_OVERLAY_BACKDROP_EN
    logic [RGB_W-1:0] bd_sh;
    logic [RGB_W-1:0] bd_act;

    assign addr_is_bd = &cfg.Cfg_Addr;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bd_sh  <= '0;
            bd_act <= '0;
        end else begin
            if (line_start)
                bd_act <= bd_sh;
            if (cfg.Cfg_We && addr_is_bd)
                bd_sh <= cfg_rgb;
        end
    end

    assign dark_rgb = Enable ? bd_act : '0;
`else
    assign addr_is_bd = 1'b0;
    assign dark_rgb   = '0;
`endif

    // Ascending scan: the highest band whose start has been reached wins.
    always_comb begin
        band_rgb = act_rgb[0];
        for (int i = 0; i < NB_LOOKUP; i++) begin
            if (act_start[i] <= hcount)
                band_rgb = act_rgb[i];
        end
    end

    assign pix_rgb = Video ? (Enable ? band_rgb : RGB_ONES) : dark_rgb;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (Pix_Ce) begin
                rgb_q <= pix_rgb;
                hs_q  <= HSync;
                vs_q  <= VSync;
            end
        end
    end

    // Syncs read 0 while in reset and go inactive-high one cycle after release.
    assign O_HSYNC   = hs_q & run;
    assign O_VSYNC   = vs_q & run;
    assign O_VIDEO_R = rgb_q[2*COLOR_W +: COLOR_W];
    assign O_VIDEO_G = rgb_q[COLOR_W +: COLOR_W];
    assign O_VIDEO_B = rgb_q[0 +: COLOR_W];
    assign O_HCount  = hcount;
    assign O_VCount  = vcount;

endmodule

// File: tb/tb_mw8080_overlay.sv
// Self-checking bench for mw8080_overlay: directed scenarios plus randomized
// traffic against a pixel-level reference model of the overlay.
module tb_mw8080_overlay;
    import mw8080_pkg::*;

    localparam int NB = 5;
    localparam int CW = 1;
    localparam int HW = 9;
    localparam int VW = 9;
    localparam int AW = 3;
    localparam int DW = HW + 3 * CW;
    localparam int HMAX = (1 << HW) - 1;
    localparam int VMAX = (1 << VW) - 1;
`ifdef MW_OVERLAY_BACKDROP_EN
    localparam bit BD = 1'b1;
`else
    localparam bit BD = 1'b0;
`endif
    localparam int NB_EFF = (BD && NB == (1 << AW)) ? NB - 1 : NB;
    localparam int BD_ADDR = (1 << AW) - 1;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic Pix_Ce = 1'b0;
    logic Video = 1'b0;
    logic HSync = 1'b1;
    logic VSync = 1'b1;
    logic Enable = 1'b0;
    logic [CW-1:0] O_VIDEO_R, O_VIDEO_G, O_VIDEO_B;
    logic O_HSYNC, O_VSYNC;
    logic [HW-1:0] O_HCount;
    logic [VW-1:0] O_VCount;

    int n_tests = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mw8080_overlay_if #(.ADDR_W(AW), .DATA_W(DW)) cfg_bus ();

    mw8080_overlay #(
        .NUM_BANDS (NB),
        .COLOR_W   (CW),
        .HC_W      (HW),
        .VC_W      (VW)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Pix_Ce    (Pix_Ce),
        .Video     (Video),
        .HSync     (HSync),
        .VSync     (VSync),
        .Enable    (Enable),
        .cfg       (cfg_bus),
        .O_VIDEO_R (O_VIDEO_R),
        .O_VIDEO_G (O_VIDEO_G),
        .O_VIDEO_B (O_VIDEO_B),
        .O_HSYNC   (O_HSYNC),
        .O_VSYNC   (O_VSYNC),
        .O_HCount  (O_HCount),
        .O_VCount  (O_VCount)
    );

    // Reference model: band tables as arrays, raster position as integers.
    band_t m_sh [NB];
    band_t m_act [NB];
    rgb_t m_bd_sh, m_bd_act, m_out;
    int m_hc, m_vc;
    bit m_hs_prev, m_vs_prev, m_hs_o, m_vs_o, m_run;

    function automatic rgb_t band_colour(input int hc);
        for (int i = NB_EFF - 1; i >= 0; i--)
            if (int'(m_act[i].start) <= hc) return m_act[i].rgb;
        return m_act[0].rgb;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_sh[i]  = '{start: '0, rgb: RGB_WHITE};
            m_act[i] = '{start: '0, rgb: RGB_WHITE};
        end
        m_bd_sh = RGB_BLACK; m_bd_act = RGB_BLACK; m_out = RGB_BLACK;
        m_hc = 0; m_vc = 0;
        m_hs_prev = 1; m_vs_prev = 1; m_hs_o = 1; m_vs_o = 1; m_run = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit hs_fall, vs_fall;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        m_run = 1;
        if (Pix_Ce) begin
            if (Video) m_out = Enable ? band_colour(m_hc) : RGB_WHITE;
            else       m_out = (BD && Enable) ? m_bd_act : RGB_BLACK;
            m_hs_o = HSync; m_vs_o = VSync;
            hs_fall = m_hs_prev && !HSync;
            vs_fall = m_vs_prev && !VSync;
            if (hs_fall) begin
                m_hc = 0;
                if (m_vc < VMAX) m_vc++;
                m_act = m_sh;
                m_bd_act = m_bd_sh;
            end else if (m_hc < HMAX) m_hc++;
            if (vs_fall) m_vc = 0;
            m_hs_prev = HSync; m_vs_prev = VSync;
        end
        if (cfg_bus.Cfg_We) begin
            if (BD && int'(cfg_bus.Cfg_Addr) == BD_ADDR)
                m_bd_sh = rgb_t'(cfg_bus.Cfg_Data[3*CW-1:0]);
            else if (int'(cfg_bus.Cfg_Addr) < NB)
                m_sh[int'(cfg_bus.Cfg_Addr)] = band_t'(cfg_bus.Cfg_Data);
        end
    endtask

    function automatic logic [22:0] act_vec();
        return {O_VIDEO_R, O_VIDEO_G, O_VIDEO_B, O_HSYNC, O_VSYNC, O_HCount, O_VCount};
    endfunction

    function automatic logic [22:0] exp_vec();
        return {m_out, m_run & m_hs_o, m_run & m_vs_o, HW'(m_hc), VW'(m_vc)};
    endfunction

    function automatic logic [2:0] act_rgb();
        return {O_VIDEO_R, O_VIDEO_G, O_VIDEO_B};
    endfunction

    task automatic tick();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic cfg_write(input int addr, input logic [DW-1:0] data);
        cfg_bus.Cfg_We = 1'b1;
        cfg_bus.Cfg_Addr = AW'(addr);
        cfg_bus.Cfg_Data = data;
        tick();
        cfg_bus.Cfg_We = 1'b0;
    endtask

    task automatic hs_edge();
        HSync = 1'b1;
        tick();
        HSync = 1'b0;
        tick();
        HSync = 1'b1;
    endtask

    task automatic run_to_hc(input int target);
        int n = 0;
        while (m_hc != target && n < 700) begin
            tick();
            n++;
        end
        if (m_hc != target) begin
            n_tests++; n_fail++;
            $display("FAIL run_to_hc: timed out, count %0d required %0d", m_hc, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_tests++;
        if (act_vec() !== 23'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", act_vec());
        end
        Rst_n = 1'b1; Pix_Ce = 1'b1;
        tick();
        n_tests++;
        if ({O_HSYNC, O_VSYNC, act_rgb()} !== 5'b11000) begin
            n_fail++; $display("FAIL reset_release: got %b required 11000", {O_HSYNC, O_VSYNC, act_rgb()});
        end
    endtask

    task automatic test_default_white();
        logic hs_in;
        Video = 1'b1; Enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            hs_in = ($urandom % 3) != 0;
            HSync = hs_in;
            tick();
            n_tests++;
            if ({act_rgb(), O_HSYNC} !== {3'b111, hs_in}) begin
                n_fail++; $display("FAIL default_white: got %b required %b", {act_rgb(), O_HSYNC}, {3'b111, hs_in});
            end
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL default_white_model: got %h required %h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_bands();
        cfg_write(0, {9'd0, 3'b010});
        cfg_write(1, {9'd32, 3'b100});
        for (int i = 2; i < NB; i++) cfg_write(i, {9'd511, 3'b111});
        hs_edge();
        Video = 1'b1; Enable = 1'b1;
        run_to_hc(10);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b010) begin
            n_fail++; $display("FAIL band0_at_10: got %b required 010", act_rgb());
        end
        run_to_hc(40);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b100) begin
            n_fail++; $display("FAIL band1_at_40: got %b required 100", act_rgb());
        end
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL bands_model: got %h required %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_midline_write();
        hs_edge();
        run_to_hc(100);
        cfg_write(1, {9'd32, 3'b001});
        n_tests++;
        if (act_rgb() !== 3'b100) begin
            n_fail++; $display("FAIL midline_same_pixel: got %b required 100", act_rgb());
        end
        run_to_hc(200);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b100) begin
            n_fail++; $display("FAIL midline_rest_of_line: got %b required 100", act_rgb());
        end
        hs_edge();
        run_to_hc(40);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b001) begin
            n_fail++; $display("FAIL midline_next_line: got %b required 001", act_rgb());
        end
        run_to_hc(60);
        HSync = 1'b0;
        cfg_bus.Cfg_We = 1'b1; cfg_bus.Cfg_Addr = AW'(1); cfg_bus.Cfg_Data = {9'd32, 3'b110};
        tick();
        cfg_bus.Cfg_We = 1'b0; HSync = 1'b1;
        run_to_hc(40);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b001) begin
            n_fail++; $display("FAIL coincident_first_line: got %b required 001", act_rgb());
        end
        hs_edge();
        run_to_hc(40);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b110) begin
            n_fail++; $display("FAIL coincident_second_line: got %b required 110", act_rgb());
        end
    endtask

    task automatic test_bad_addr_enable();
        cfg_write(5, {9'd0, 3'b000});
        cfg_write(6, {9'd0, 3'b000});
        hs_edge();
        hs_edge();
        run_to_hc(40);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b110) begin
            n_fail++; $display("FAIL bad_addr_ignored: got %b required 110", act_rgb());
        end
        Enable = 1'b0;
        run_to_hc(50);
        tick();
        n_tests++;
        if (act_rgb() !== 3'b111) begin
            n_fail++; $display("FAIL enable_off_white: got %b required 111", act_rgb());
        end
        Video = 1'b0; Enable = 1'b1;
        tick();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL unlit_model: got %h required %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_pix_ce();
        HSync = 1'b0; Pix_Ce = 1'b1;
        tick();
        HSync = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            Pix_Ce = (k % 4) == 0;
            Video = $urandom % 2;
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pix_ce_model k=%0d: got %h required %h", k, act_vec(), exp_vec());
            end
        end
        n_tests++;
        if (O_HCount !== 9'd8) begin
            n_fail++; $display("FAIL pix_ce_hcount: got %0d required 8", O_HCount);
        end
        Pix_Ce = 1'b1; VSync = 1'b0;
        tick();
        VSync = 1'b1;
        n_tests++;
        if (O_VCount !== 9'd0) begin
            n_fail++; $display("FAIL vsync_vcount: got %0d required 0", O_VCount);
        end
    endtask

    task automatic test_mid_reset();
        Video = 1'b1; Enable = 1'b1; Pix_Ce = 1'b1;
        run_to_hc(50);
        #2 Rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (act_vec() !== 23'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", act_vec());
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        hs_edge();
        run_to_hc(20);
        tick();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL after_reset_model: got %h required %h", act_vec(), exp_vec());
        end
    endtask

`ifdef MW_OVERLAY_BACKDROP_EN
    task automatic test_backdrop();
        cfg_write(BD_ADDR, {9'd0, 3'b001});
        hs_edge();
        Video = 1'b0; Enable = 1'b1;
        tick();
        n_tests++;
        if (act_rgb() !== 3'b001) begin
            n_fail++; $display("FAIL backdrop_colour: got %b required 001", act_rgb());
        end
        run_to_hc(30);
        #2 Rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (act_vec() !== 23'd0) begin
            n_fail++; $display("FAIL backdrop_reset_outputs: got %h required 0", act_vec());
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        hs_edge();
        tick();
        n_tests++;
        if (act_rgb() !== 3'b000) begin
            n_fail++; $display("FAIL backdrop_after_reset: got %b required 000", act_rgb());
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 2500; c++) begin
            Pix_Ce = ($urandom % 4) != 0;
            Video = $urandom % 2;
            Enable = ($urandom % 8) != 0;
            HSync = ($urandom % 60) != 0;
            VSync = ($urandom % 400) != 0;
            cfg_bus.Cfg_We = ($urandom % 6) == 0;
            cfg_bus.Cfg_Addr = AW'($urandom % 8);
            cfg_bus.Cfg_Data = DW'($urandom);
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random c=%0d: got %h required %h", c, act_vec(), exp_vec());
            end
        end
        cfg_bus.Cfg_We = 1'b0;
    endtask

    initial begin
        cfg_bus.Cfg_We = 1'b0;
        cfg_bus.Cfg_Addr = '0;
        cfg_bus.Cfg_Data = '0;
        model_reset();
        test_reset();
        test_default_white();
        test_bands();
        test_midline_write();
        test_bad_addr_enable();
        test_pix_ce();
        test_mid_reset();
`ifdef MW_OVERLAY_BACKDROP_EN
        test_backdrop();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mw8080_overlay.md
Name: mw8080_overlay

Overview:
- Parametrised colour-overlay generator for Midway/Taito 8080 monochrome cores; replaces the fixed per-game overlay blocks.
- Sits between the game core's 1-bit Video/HSync/VSync outputs and mist_video.
- Tracks raster position internally and tints video by up to NUM_BANDS run-time programmable vertical-strip bands, selected by horizontal count (the monitor is rotated).
- Band table is written through a simple config port with tear-free commit at line start.

Parameters:
NUM_BANDS, 4, number of colour bands (1..16)
COLOR_W, 1, bits per colour channel
HC_W, 9, horizontal pixel counter width
VC_W, 9, vertical line counter width
BAND_AW (localparam), max(1,$clog2(NUM_BANDS)), band address width

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Pix_Ce  in  1  pixel clock enable
Video  in  1  core pixel, 1 = lit
HSync  in  1  core horizontal sync, active low
VSync  in  1  core vertical sync, active low
Enable  in  1  1 = overlay on, 0 = plain white
Cfg_We  in  1  band table write strobe, one Clk cycle
Cfg_Addr  in  BAND_AW  band index
Cfg_Data  in  HC_W+3*COLOR_W  {start[HC_W-1:0], R, G, B}
O_VIDEO_R/G/B  out  COLOR_W each  tinted pixel
O_HSYNC, O_VSYNC  out  1  syncs delayed to match video
O_HCount  out  HC_W  current pixel count (debug)
O_VCount  out  VC_W  current line count (debug)

Behaviour:
- One clock (Clk), reset asynchronous active-low (Rst_n). All state is clocked by Clk and qualified by Pix_Ce unless stated otherwise.
- Reset values:
  - All outputs 0; both counters 0.
  - Sync delay registers 1, so O_HSYNC/O_VSYNC = 1 (inactive) after the first cycle.
  - Shadow and active tables: start = 0, colour = all ones.
- Counters:
  - HSync falling edge (sampled on a Pix_Ce cycle): HCount <= 0, VCount <= VCount+1 (saturates at all ones), commit shadow->active.
  - Otherwise HCount <= HCount+1 on Pix_Ce, saturating at all ones.
  - VSync falling edge: VCount <= 0.
  - Edges are detected against the previous Pix_Ce-sampled value.
- Band lookup: the selected band is the highest index i with active start[i] <= HCount. None matching yields band 0.
- Config:
  - Cfg_We writes the shadow entry Cfg_Addr; effective at any cycle, independent of Pix_Ce.
  - Writes with Cfg_Addr >= NUM_BANDS are ignored.
  - If a write and a commit occur in the same cycle, the commit takes the pre-write shadow value; the new value is committed at the next line.
- Output pipeline:
  - Registered, latency exactly one Pix_Ce cycle from Video/HSync/VSync to O_*.
  - Video=1 and Enable=1: band colour. Video=1 and Enable=0: all ones. Video=0: 0.
- Mid-operation reset clears the counters, both tables and the pipeline immediately (asynchronous). The first HSync edge after release is treated normally.
- Pix_Ce held low freezes counters and outputs. Config writes still land in the shadow table.

Optional Feature:
MW_OVERLAY_BACKDROP_EN
- With the macro defined:
  - An extra table entry at Cfg_Addr = all ones (BAND_AW bits) holds the backdrop colour (start field ignored), reset 0, committed like the bands.
  - Video=0 with Enable=1 outputs the backdrop colour. If NUM_BANDS equals 2^BAND_AW, that address aliases the backdrop, not the band.
- Without it: Video=0 always outputs 0 and the entry does not exist.

Decomposition:
- Package mw8080_pkg:
  - rgb_t (packed R/G/B, COLOR_W each) and band_t (start + rgb_t);
  - constants for reset colour (white) and default backdrop (black).
- Sub-module mw8080_raster_cnt: sync edge detection plus HCount/VCount. Emits line_start and frame_start pulses used for commit.

Test Plan:
- Reset, no config, Video=1, Enable=1, Pix_Ce always 1 -> O_VIDEO_R/G/B = 1/1/1 one cycle after Video, O_HSYNC follows HSync delayed one cycle.
- NUM_BANDS=4, COLOR_W=1:
  - write band0 {0,R=0,G=1,B=0} and band1 {32,R=1,G=0,B=0};
  - after the next HSync edge, Video=1 at HCount=10 -> 0/1/0;
  - Video=1 at HCount=40 -> 1/0/0.
- Write band1 colour mid-line at HCount=100 -> current line keeps old colour; new colour appears from the next line start. Write and HSync edge in the same cycle -> new value appears two lines later.
- Cfg_Addr=5 with NUM_BANDS=4 -> table unchanged; Enable=0 with Video=1 -> 1/1/1 regardless of band.
- Pix_Ce toggling 1-of-4: 8 pixels -> HCount = 8, outputs change only on Pix_Ce cycles; VSync low edge -> VCount = 0.
- With MW_OVERLAY_BACKDROP_EN, backdrop {R=0,G=0,B=1}, Video=0 -> 0/0/1 after commit; assert Rst_n low mid-line -> outputs 0 immediately and backdrop returns to 0.
